data_mem_ctrl: RTL and testbench

Data-memory access controller for the 16-bit pipelined CPU. It sits downstream of the ALU's LW/SW address computation and acts as the responder for the pipeline's memory request. It accepts one load or store per transaction and drives a variable-latency main-memory port. It stalls the pipeline until the memory acknowledges, then returns load data and a completion/error indication.

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/wait_counter.sv | 28 ++
 rtl/data_mem_ctrl.sv | 110 +++++++++++
 tb/tb_data_mem_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

    // Controller phases: accept, strobe memory, wait for ack, report result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default number of WAIT cycles before an access is abandoned.
    localparam int TIMEOUT_DEF = 16;

endpackage : mem_ctrl_pkg

// File: rtl/wait_counter.sv
// Counts WAIT cycles and flags the last cycle before a timeout.
module wait_counter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    // Clear has priority so every access starts counting from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule : wait_counter

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: accepts one LW/SW from the pipeline,
// drives a variable-latency memory port and reports data or error.
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        stall,
    output logic        rdata_valid,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output state_t      fsm_state
);

    // Handshake: a request is taken only in IDLE with req_valid high; the
    // pipeline must hold while stall is high. mem_en is a one-cycle strobe
    // and mem_ack is honoured only while waiting for it.

    state_t state;
    logic   pend_err;
    logic   tc;

    wait_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (state == REQ),
        .en  (state == WAIT),
        .tc  (tc)
    );

    // FSM with registered strobes, request latches and load-data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            pend_err    <= 1'b0;
        end else begin
            mem_en      <= 1'b0;
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_addr[0]) begin
                            mem_we    <= req_we;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                            mem_en    <= 1'b1;
                            state     <= REQ;
                        end else begin
                            // Odd byte address: never touch memory.
                            pend_err <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // An ack on the terminal-count cycle still counts as success.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            rdata       <= mem_rdata;
                            rdata_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (tc) begin
                        pend_err <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    pend_err <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The pending-error flag is set on entry to DONE and cleared on exit,
    // so it is exactly the err pulse.
    assign err       = pend_err;
    assign stall     = ((state == IDLE) && req_valid) || (state == REQ) || (state == WAIT);
    assign fsm_state = state;

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl.
module tb_data_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        stall, rdata_valid, err, mem_en, mem_we, mem_ack;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    state_t      fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Results gathered by do_access.
    int          r_stall, r_en, r_rv, r_err, r_done;
    logic [15:0] r_rd, r_addr, r_wdata;
    logic        r_we;

    data_mem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .err         (err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request at cycle 0, ack at cycle ack_at (-1: never), and
    // record what the controller does until one cycle after DONE.
    task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input int ack_at, input logic [15:0] ack_data);
        r_stall = 0; r_en = 0; r_rv = 0; r_err = 0; r_done = -1;
        r_rd = '0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
        for (int i = 0; i < 40; i++) begin
            req_valid = (i == 0);
            req_we    = we;
            req_addr  = addr;
            req_wdata = wdata;
            mem_ack   = (i == ack_at);
            mem_rdata = (i == ack_at) ? ack_data : 16'h0000;
            #1;
            if (stall) r_stall++;
            if (mem_en) begin
                r_en++;
                r_we    = mem_we;
                r_addr  = mem_addr;
                r_wdata = mem_wdata;
            end
            if (rdata_valid) r_rv++;
            if (err) r_err++;
            if (fsm_state == DONE && r_done < 0) begin
                r_done = i;
                r_rd   = rdata;
            end
            cyc();
            if (r_done >= 0 && i > r_done) break;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #3 rst = 1'b0;
        cyc(); cyc(); #1;
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err_rv", 32'({err, rdata_valid}), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();

        // Load, ack 4 cycles after mem_en
        do_access(1'b0, 16'h0010, 16'h0000, 5, 16'hBEEF);
        chk("ld_stall", 32'(r_stall), 32'd6);
        chk("ld_en", 32'(r_en), 32'd1);
        chk("ld_we", 32'(r_we), 32'd0);
        chk("ld_addr", 32'(r_addr), 32'h0010);
        chk("ld_done", 32'(r_done), 32'd6);
        chk("ld_rv", 32'(r_rv), 32'd1);
        chk("ld_rdata", 32'(r_rd), 32'hBEEF);
        chk("ld_err", 32'(r_err), 32'd0);

        // Store, minimum latency
        do_access(1'b1, 16'h0020, 16'h1234, 2, 16'hAAAA);
        chk("st_stall", 32'(r_stall), 32'd3);
        chk("st_we", 32'(r_we), 32'd1);
        chk("st_wdata", 32'(r_wdata), 32'h1234);
        chk("st_rv", 32'(r_rv), 32'd0);
        chk("st_rdata_kept", 32'(rdata), 32'hBEEF);
        chk("st_wdata_kept", 32'(mem_wdata), 32'h1234);

        // Misaligned load
        do_access(1'b0, 16'h0011, 16'h0000, -1, 16'h0000);
        chk("mis_en", 32'(r_en), 32'd0);
        chk("mis_stall", 32'(r_stall), 32'd1);
        chk("mis_done", 32'(r_done), 32'd1);
        chk("mis_err", 32'(r_err), 32'd1);

        // Timeout, then a stray ack, then a normal load
        do_access(1'b0, 16'h0030, 16'h0000, -1, 16'h0000);
        chk("to_done", 32'(r_done), 32'd18);
        chk("to_stall", 32'(r_stall), 32'd18);
        chk("to_err", 32'(r_err), 32'd1);
        chk("to_rv", 32'(r_rv), 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        chk("stray_state", 32'(fsm_state), 32'(IDLE));
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("stray_after", 32'({fsm_state, rdata_valid, stall}), 32'({IDLE, 1'b0, 1'b0}));
        chk("stray_rdata", 32'(rdata), 32'hBEEF);
        cyc();
        do_access(1'b0, 16'h0040, 16'h0000, 2, 16'h5A5A);
        chk("post_to_done", 32'(r_done), 32'd3);
        chk("post_to_rdata", 32'(r_rd), 32'h5A5A);

        // Ack on the terminal-count cycle
        do_access(1'b0, 16'h0042, 16'h0000, 17, 16'hC0DE);
        chk("col_done", 32'(r_done), 32'd18);
        chk("col_err", 32'(r_err), 32'd0);
        chk("col_rv", 32'(r_rv), 32'd1);
        chk("col_rdata", 32'(r_rd), 32'hC0DE);

        // Reset during WAIT
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0050;
        #1 chk("rw_accept", 32'(stall), 32'd1);
        cyc();
        req_valid = 1'b0;
        #1 chk("rw_en", 32'(mem_en), 32'd1);
        cyc();
        #1 chk("rw_wait", 32'(fsm_state), 32'(WAIT));
        cyc();
        rst = 1'b0;
        #1;
        chk("rw_state", 32'(fsm_state), 32'(IDLE));
        chk("rw_addr", 32'(mem_addr), 32'd0);
        chk("rw_wdata", 32'(mem_wdata), 32'd0);
        chk("rw_rdata", 32'(rdata), 32'd0);
        chk("rw_outs", 32'({stall, mem_en, err, rdata_valid}), 32'd0);
        cyc();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        #1 chk("rw_ack_state", 32'(fsm_state), 32'(IDLE));
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("rw_ack_ignored", 32'({fsm_state, rdata_valid}), 32'({IDLE, 1'b0}));
        chk("rw_ack_rdata", 32'(rdata), 32'd0);
        cyc();

        // Back-to-back with req_valid held through DONE
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0060;
        #1 chk("bb_accept", 32'(stall), 32'd1);
        cyc();
        #1 chk("bb_req", 32'(fsm_state), 32'(REQ));
        cyc();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        #1 chk("bb_wait", 32'(fsm_state), 32'(WAIT));
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("bb_done", 32'(fsm_state), 32'(DONE));
        chk("bb_done_stall", 32'(stall), 32'd0);
        chk("bb_rv1", 32'({rdata_valid, rdata}), 32'({1'b1, 16'h1111}));
        cyc();
        #1;
        chk("bb_idle", 32'(fsm_state), 32'(IDLE));
        chk("bb_idle_stall", 32'(stall), 32'd1);
        cyc();
        req_valid = 1'b0;
        #1 chk("bb_req2", 32'({fsm_state, mem_en}), 32'({REQ, 1'b1}));
        cyc();
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        #1;
        cyc();
        mem_ack = 1'b0;
        #1 chk("bb_rv2", 32'({fsm_state, rdata_valid, rdata}), 32'({DONE, 1'b1, 16'h2222}));
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_data_mem_ctrl
